ama_riscv_pipe_ctrl: RTL

- Central stall/flush sequencer for the 5-stage core: fetch, decode, execute, memory, writeback, retire.
- Takes stall and hazard requests from the icache, dcache, decoder, branch resolution and CSR unit.
- Drives the per-boundary stage_ctrl_t (en, bubble) for every pipeline register, plus the fetch enable and redirect strobe.
- Serialising instructions drain the pipe through a small FSM; a mispredict that arrives during a dcache stall is held pending until the stall clears.

---
 rtl/ama_riscv_pipe_ctrl_pkg.sv | 30 +++
 rtl/ama_riscv_pipe_ctrl_if.sv | 35 +++
 rtl/ama_riscv_sat_cnt.sv | 26 ++
 rtl/ama_riscv_pipe_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/ama_riscv_pipe_ctrl_pkg.sv
// Shared pipeline-control types: stage_ctrl_t, sequencer state
// and the stall-cause priority encoding used by tracer/core view.
package ama_riscv_pipe_ctrl_pkg;

  typedef struct packed {
    logic en;
    logic bubble;
  } stage_ctrl_t;

  typedef enum logic {
    PC_RUN   = 1'b0,
    PC_DRAIN = 1'b1
  } pipe_ctrl_state_t;

  typedef logic [2:0] stall_cause_t;

  // Larger value = higher priority
  localparam stall_cause_t CAUSE_NONE  = 3'd0;
  localparam stall_cause_t CAUSE_IC    = 3'd1;
  localparam stall_cause_t CAUSE_LU    = 3'd2;
  localparam stall_cause_t CAUSE_SER   = 3'd3;
  localparam stall_cause_t CAUSE_DRAIN = 3'd4;
  localparam stall_cause_t CAUSE_FLUSH = 3'd5;
  localparam stall_cause_t CAUSE_DC    = 3'd6;

  localparam stage_ctrl_t SC_RUN  = '{en: 1'b1, bubble: 1'b0};
  localparam stage_ctrl_t SC_HOLD = '{en: 1'b0, bubble: 1'b0};
  localparam stage_ctrl_t SC_BUB  = '{en: 1'b1, bubble: 1'b1};

endpackage

// File: rtl/ama_riscv_pipe_ctrl_if.sv
// Request/control bundle between the pipe sequencer and the stages.
// master = core side (drives requests), slave = sequencer.
interface ama_riscv_pipe_ctrl_if;
  import ama_riscv_pipe_ctrl_pkg::*;

  logic        ic_stalled;
  logic        dc_stalled;
  logic        load_use;
  logic        mispredict;
  logic        serialize_exe;
  stage_ctrl_t ctrl_fet_dec;
  stage_ctrl_t ctrl_dec_exe;
  stage_ctrl_t ctrl_exe_mem;
  stage_ctrl_t ctrl_mem_wbk;
  stage_ctrl_t ctrl_wbk_ret;
  logic        fetch_en;
  logic        redirect;

  modport master (
    output ic_stalled, dc_stalled, load_use,
    output mispredict, serialize_exe,
    input  ctrl_fet_dec, ctrl_dec_exe,
    input  ctrl_exe_mem, ctrl_mem_wbk,
    input  ctrl_wbk_ret, fetch_en, redirect
  );

  modport slave (
    input  ic_stalled, dc_stalled, load_use,
    input  mispredict, serialize_exe,
    output ctrl_fet_dec, ctrl_dec_exe,
    output ctrl_exe_mem, ctrl_mem_wbk,
    output ctrl_wbk_ret, fetch_en, redirect
  );

endinterface

// File: rtl/ama_riscv_sat_cnt.sv
// Saturating up-counter with async active-low reset.
module ama_riscv_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ama_riscv_pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage core.
// Optional stall counters: define PIPE_CTRL_PERF_EN.
module ama_riscv_pipe_ctrl
  import ama_riscv_pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int PERF_CNT_W   = 32
) (
  input  logic clk,
  input  logic rst_n,
  ama_riscv_pipe_ctrl_if.slave pc
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_dc_stall,
  output logic [PERF_CNT_W-1:0] perf_load_use,
  output logic [PERF_CNT_W-1:0] perf_flush,
  output logic [PERF_CNT_W-1:0] perf_drain
`endif
);

  localparam int CW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'(DRAIN_CYCLES - 1);

  pipe_ctrl_state_t state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;
  stall_cause_t     cause;
  logic             flush;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    cause        = CAUSE_NONE;
    flush        = pc.mispredict | flush_pend_q;

    case (state_q)
      PC_RUN: ;
      PC_DRAIN: begin
        if (!pc.dc_stalled) begin
          if (cnt_q == '0) state_d = PC_RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = PC_RUN;
    endcase

    if (pc.dc_stalled) begin
      cause = CAUSE_DC;
      if (pc.mispredict) flush_pend_d = 1'b1;
    end else if (flush) begin
      cause        = CAUSE_FLUSH;
      flush_pend_d = 1'b0;
      if (pc.serialize_exe) begin
        state_d = PC_DRAIN;
        cnt_d   = CNT_INIT;
      end
    end else if (state_q == PC_DRAIN) begin
      cause = CAUSE_DRAIN;
    end else if (pc.serialize_exe) begin
      // inst advances to mem this cycle
      cause   = CAUSE_SER;
      state_d = PC_DRAIN;
      cnt_d   = CNT_INIT;
    end else if (pc.load_use) begin
      cause = CAUSE_LU;
    end else if (pc.ic_stalled) begin
      cause = CAUSE_IC;
    end
  end

  always_comb begin
    pc.ctrl_fet_dec = SC_RUN;
    pc.ctrl_dec_exe = SC_RUN;
    pc.ctrl_exe_mem = SC_RUN;
    pc.ctrl_mem_wbk = SC_RUN;
    pc.ctrl_wbk_ret = SC_RUN;
    pc.fetch_en     = 1'b1;
    pc.redirect     = 1'b0;
    unique case (cause)
      CAUSE_DC: begin
        pc.ctrl_fet_dec = SC_HOLD;
        pc.ctrl_dec_exe = SC_HOLD;
        pc.ctrl_exe_mem = SC_HOLD;
        pc.ctrl_mem_wbk = SC_BUB;
        pc.fetch_en     = 1'b0;
      end
      CAUSE_FLUSH: begin
        pc.ctrl_fet_dec = SC_BUB;
        pc.ctrl_dec_exe = SC_BUB;
        pc.redirect     = 1'b1;
      end
      CAUSE_DRAIN, CAUSE_LU: begin
        pc.ctrl_fet_dec = SC_HOLD;
        pc.ctrl_dec_exe = SC_BUB;
        pc.fetch_en     = 1'b0;
      end
      CAUSE_IC: begin
        pc.ctrl_fet_dec = SC_BUB;
        pc.fetch_en     = 1'b0;
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc.ctrl_fet_dec = SC_BUB;
      pc.ctrl_dec_exe = SC_BUB;
      pc.ctrl_exe_mem = SC_BUB;
      pc.ctrl_mem_wbk = SC_BUB;
      pc.ctrl_wbk_ret = SC_BUB;
      pc.fetch_en     = 1'b0;
      pc.redirect     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PC_RUN;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  ama_riscv_sat_cnt #(.W(PERF_CNT_W)) u_perf_dc (
    .clk(clk), .rst_n(rst_n),
    .inc(cause == CAUSE_DC), .cnt(perf_dc_stall)
  );
  ama_riscv_sat_cnt #(.W(PERF_CNT_W)) u_perf_lu (
    .clk(clk), .rst_n(rst_n),
    .inc(cause == CAUSE_LU), .cnt(perf_load_use)
  );
  ama_riscv_sat_cnt #(.W(PERF_CNT_W)) u_perf_fl (
    .clk(clk), .rst_n(rst_n),
    .inc(cause == CAUSE_FLUSH), .cnt(perf_flush)
  );
  ama_riscv_sat_cnt #(.W(PERF_CNT_W)) u_perf_dr (
    .clk(clk), .rst_n(rst_n),
    .inc(cause == CAUSE_DRAIN), .cnt(perf_drain)
  );
`endif

endmodule
